// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell: S = A^B^Cin, C = majority(A,B,Cin).
// Purely combinational, zero latency, no flow control.
module serial_adder_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic C
);

  assign S = A ^ B ^ Cin;
  assign C = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder {Cout,S} = A+B+Cin, LSB first; optional signed overflow V with SERIAL_ADDER_OVF_EN.
// Start accepted only in IDLE (never queued); busy WIDTH cycles, done pulse at cycle WIDTH+1.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sum;
  logic             cell_c;

  serial_adder_fa u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (carry),
    .S   (sum),
    .C   (cell_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      V     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
            S     <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          S     <= {sum, S[WIDTH-1:1]};
          carry <= cell_c;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // Result lands together with done so it is valid for the whole DONE cycle.
            busy  <= 1'b0;
            done  <= 1'b1;
            Cout  <= cell_c;
`ifdef SERIAL_ADDER_OVF_EN
            V     <= carry ^ cell_c;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder: plain-arithmetic model, done-driven monitor.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         V;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .V     (V)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         v;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   busy_run = 0;
  logic done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact (W+1)-bit unsigned sum; overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int due);
    exp_t e;
    logic [W:0] tot;
    tot    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.s    = tot[W-1:0];
    e.cout = tot[W];
    e.v    = (a[W-1] == b[W-1]) && (tot[W-1] != a[W-1]);
    e.due  = due;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        chk("done_single_cycle", {63'd0, done_prev}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sum", {{(64-W){1'b0}}, S}, {{(64-W){1'b0}}, e.s});
          chk("cout", {63'd0, Cout}, {63'd0, e.cout});
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", {63'd0, V}, {63'd0, e.v});
`endif
          chk("done_cycle", 64'(cyc), 64'(e.due));
          chk("busy_cycles", 64'(busy_run), 64'(W));
        end
        busy_run = 0;
      end
    end
    done_prev = done;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_S"}, {{(64-W){1'b0}}, S}, 64'd0);
    chk({tag, "_Cout"}, {63'd0, Cout}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_V"}, {63'd0, V}, 64'd0);
`endif
  endtask

  task automatic wait_done();
    for (int n = 0; n < 4 * W; n++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  // mode 0: clean; 1: start pulses at cycles 3 and 5, operands changed at 4; 2: random noise.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int mode);
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    sb.push_back(model(a, b, cin, cyc + W + 1));
    @(negedge clk);
    start = 1'b0;
    if (mode != 0) begin
      for (int c = 2; c <= W; c++) begin
        @(negedge clk);
        if (mode == 1) begin
          start = (c == 3 || c == 5);
          if (c == 4) begin
            A = ~a; B = a ^ b; Cin = ~cin;
          end
        end else begin
          start = 1'($urandom_range(0, 1));
          A = W'($urandom); B = W'($urandom); Cin = 1'($urandom_range(0, 1));
        end
      end
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    int prev_due;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run_op(8'h3C, 8'h0F, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'h01, 1'b1, 0);
    run_op(8'h5A, 8'h33, 1'b0, 1);

    // Reset during SHIFT cycle 4: no done, partial result dropped.
    @(negedge clk);
    A = 8'hC3; B = 8'h77; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    chk_zero("midrst_hold");
    rst_n = 1'b1;
    run_op(8'hAA, 8'h55, 1'b1, 0);

    // start held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    A = 8'h12; B = 8'hF0; Cin = 1'b1; start = 1'b1;
    prev_due = cyc + W + 1;
    sb.push_back(model(A, B, Cin, prev_due));
    for (int k = 1; k < 3; k++) begin
      wait_done();
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom_range(0, 1));
      prev_due = prev_due + W + 2;
      sb.push_back(model(A, B, Cin, prev_due));
    end
    wait_done();
    start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 7 == 0) ra = '1;
      if (i % 11 == 0) rb = '0;
      run_op(ra, rb, 1'($urandom_range(0, 1)), (i % 3 == 0) ? 2 : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder; the sequential stage wrapped around the team's one-bit full-adder cell.
- Loads two WIDTH-bit operands and a carry-in on a start pulse.
- Presents one LSB-first bit pair per clock to the full-adder cell, with the carry registered between cycles.
- Shifts the sum bits into a result register and flags completion; trades area for WIDTH cycles of latency in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  operand A, captured on accepted start
- B  in  WIDTH  operand B, captured on accepted start
- Cin  in  1  carry-in, captured on accepted start
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse when S/Cout are valid
- S  out  WIDTH  sum result register
- Cout  out  1  final carry-out register

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, S=0, Cout=0, internal shift regs/carry/counter=0.
- States:
  - IDLE -> SHIFT on start=1. In that cycle: capture A, B, Cin; counter=0; S cleared to 0.
  - SHIFT: each cycle feed bit0 of A-shift and B-shift, plus carry flop, into the full-adder cell.
    - Shift both operand regs right by one.
    - Shift the sum bit into S from the MSB side (S <= {sum, S[WIDTH-1:1]}).
    - carry flop <= cell carry; counter++.
    - When counter reaches WIDTH-1 on the current cycle, go to DONE next.
  - DONE: done=1 for exactly one cycle; Cout=carry flop; S holds the final sum; -> IDLE.
- Latency: start accepted at cycle 0; SHIFT occupies cycles 1..WIDTH; done high at cycle WIDTH+1.
- busy=1 exactly WIDTH cycles.
- S and Cout hold their values after DONE until the next accepted start.
- start during SHIFT or DONE: ignored, not queued.
- start held high continuously: a new operation begins on the IDLE cycle after DONE. Back-to-back throughput is one result per WIDTH+2 cycles.
- A/B/Cin changes while busy have no effect.
- Arithmetic: {Cout,S} = A + B + Cin, unsigned, WIDTH+1 bits exact; wrap of S is implied by Cout.
- Reset mid-operation: immediate return to the reset values; no done pulse; the partial result is discarded.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port V (1 bit) = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Carry into MSB is captured during the last SHIFT cycle.
  - V updates with Cout in DONE, resets to 0, holds like S.
- Undefined: no V port, no extra flop; behaviour otherwise identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state typedef {IDLE, SHIFT, DONE} (2-bit encoding);
  - default WIDTH constant.
- One sub-module, natural and required: the team's existing one-bit full-adder cell (inputs A, B, Cin; outputs S, C), instantiated once.
- No further hierarchy.

Test Plan:
- Reset, then WIDTH=8, A=0x3C, B=0x0F, Cin=0, start 1 cycle -> busy 8 cycles, done at cycle 9, S=0x4B, Cout=0.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1. With SERIAL_ADDER_OVF_EN: V=0.
- A=0x7F, B=0x01, Cin=1 -> S=0x81, Cout=0. With SERIAL_ADDER_OVF_EN: V=1.
- Pulse start again at cycles 3 and 5 of a running add, and change A/B mid-run -> ignored; result matches the originally captured operands; exactly one done.
- Assert rst_n=0 at SHIFT cycle 4 -> all outputs 0 immediately; no done; a fresh start afterwards with A=0xAA, B=0x55, Cin=1 gives S=0x00, Cout=1.
- start held high across 3 operations -> done pulses spaced 10 cycles apart (WIDTH+2); each result correct.
